// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM states, data width and the
// response record returned to the requester.
package apb_pkg;

    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// Single-channel APB3 initiator: one command in, one APB transfer out,
// one response back. Stalled transfers are aborted after TIMEOUT wait cycles.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0, exactly one cycle
// ACCESS | psel=1, penable=1, waiting for pready or the timeout
// RESP   | rsp_valid high, response held until rsp_ready
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_DATA_W-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    // Wait-counter value of the last ACCESS cycle allowed before abort.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e            state_q, state_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic                  pwrite_d, psel_d, penable_d;
    logic [APB_DATA_W-1:0] pwdata_d;
    apb_rsp_t              rsp_q, rsp_d;

    // Next-state and next-register values; everything holds by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr;
        pwrite_d  = pwrite;
        pwdata_d  = pwdata;
        psel_d    = psel;
        penable_d = penable;
        rsp_d     = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A completing pready takes priority over a coincident timeout.
                if (pready) begin
                    rsp_d.rdata   = pwrite ? '0 : prdata;
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, wait counter and all registered outputs.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            paddr   <= paddr_d;
            pwrite  <= pwrite_d;
            pwdata  <= pwdata_d;
            psel    <= psel_d;
            penable <= penable_d;
            rsp_q   <= rsp_d;
        end
    end

    // Handshake decodes; forced low while reset is held so every output reads 0.
    assign cmd_ready   = (state_q == ST_IDLE) && !reset;
    assign rsp_valid   = (state_q == ST_RESP) && !reset;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a transaction-timeline model predicts every output
// on every cycle; directed transfers add hand-computed literal checks.
module tb_apb_master;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              cmd_ready, rsp_valid, rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err, rsp_timeout;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite, psel, penable;
    logic [31:0]       pwdata, prdata;
    logic              pready, pslverr;

    apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .pclk(pclk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at time %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction parameters the driver hands to the model.
    logic              t_write, t_slverr;
    logic [31:0]       t_rdata;
    int                t_nwait, t_rd;

    // Model state: a transfer accepted at edge acc_cyc occupies cycles k=1..
    // SETUP is k=1, ACCESS k=2..1+nacc, RESP k=2+nacc..2+nacc+rd.
    int                cyc = 0, acc_cyc = 0;
    bit                active = 0, rst_q = 0, started = 0;
    int                cur_nwait = 0, cur_nacc = 0, cur_rd = 0;
    logic              cur_write = 0, cur_slverr = 0;
    logic [31:0]       cur_rdata = 0;
    logic [ADDR_W-1:0] last_addr = 0;
    logic              last_write = 0;
    logic [31:0]       last_wdata = 0;

    function automatic int nacc_of(input int nwait);
        return (TIMEOUT != 0 && nwait >= TIMEOUT) ? TIMEOUT : nwait + 1;
    endfunction

    // Model: advance on each edge; accept only when idle and out of reset.
    always @(posedge pclk) begin
        int kend;
        started = 1;
        kend = cyc - acc_cyc + 1;
        cyc++;
        if (reset) begin
            active = 0; rst_q = 1;
            last_addr = '0; last_write = 1'b0; last_wdata = '0;
        end else begin
            rst_q = 0;
            if (active) begin
                if (kend == 2 + cur_nacc + cur_rd) active = 0;
            end else if (cmd_valid) begin
                active = 1; acc_cyc = cyc;
                cur_nwait = t_nwait; cur_nacc = nacc_of(t_nwait); cur_rd = t_rd;
                cur_write = t_write; cur_rdata = t_rdata; cur_slverr = t_slverr;
                last_addr = cmd_addr; last_write = cmd_write; last_wdata = cmd_wdata;
            end
        end
    end

    // Slave and consumer: complete after nwait low-pready ACCESS cycles,
    // hold rsp_ready low for rd RESP cycles; noise on ignored inputs otherwise.
    initial begin
        pready = 1'b1; prdata = '0; pslverr = 1'b0; rsp_ready = 1'b1;
        forever begin
            int  k;
            bit  in_acc, done, in_resp;
            @(posedge pclk); #1;
            k       = cyc - acc_cyc + 1;
            in_acc  = active && k >= 2 && k <= 1 + cur_nacc;
            done    = in_acc && (k == 2 + cur_nwait);
            in_resp = active && k >= 2 + cur_nacc;
            pready    = in_acc ? done : 1'b1;
            prdata    = done ? cur_rdata : $urandom;
            pslverr   = done ? cur_slverr : 1'b1;
            rsp_ready = in_resp ? (k == 2 + cur_nacc + cur_rd) : 1'b1;
        end
    end

    // Observed-history counters and last response, used by literal checks.
    int          cnt_psel = 0, cnt_pen = 0, cnt_rv = 0, rv_k = -1;
    logic        prev_rv = 0;
    logic [31:0] lr_rdata = 0;
    logic        lr_err = 0, lr_to = 0;

    // Compare process: every output against the model on every cycle.
    always @(negedge pclk) begin
        if (started) begin
            if (reset) begin
                chk("rst_cmd_ready", cmd_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                if (rst_q) begin
                    chk("rst_psel", psel, 0);
                    chk("rst_penable", penable, 0);
                    chk("rst_paddr", paddr, 0);
                    chk("rst_pwrite", pwrite, 0);
                    chk("rst_pwdata", pwdata, 0);
                    chk("rst_rsp_rdata", rsp_rdata, 0);
                    chk("rst_rsp_err", rsp_err, 0);
                    chk("rst_rsp_timeout", rsp_timeout, 0);
                end
                prev_rv = 0;
            end else begin
                int k;
                bit e_psel, e_pen, e_rv, timed;
                k      = cyc - acc_cyc + 1;
                e_psel = active && k <= 1 + cur_nacc;
                e_pen  = active && k >= 2 && k <= 1 + cur_nacc;
                e_rv   = active && k >= 2 + cur_nacc;
                timed  = (TIMEOUT != 0) && (cur_nwait >= TIMEOUT);
                chk("cmd_ready", cmd_ready, !active);
                chk("psel", psel, e_psel);
                chk("penable", penable, e_pen);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("paddr", paddr, last_addr);
                chk("pwrite", pwrite, last_write);
                chk("pwdata", pwdata, last_wdata);
                if (e_rv) begin
                    chk("rsp_rdata", rsp_rdata, (cur_write || timed) ? 32'h0 : cur_rdata);
                    chk("rsp_err", rsp_err, timed || cur_slverr);
                    chk("rsp_timeout", rsp_timeout, timed);
                end
                if (psel === 1'b1) cnt_psel++;
                if (penable === 1'b1) cnt_pen++;
                if (rsp_valid === 1'b1) begin
                    cnt_rv++;
                    if (!prev_rv) rv_k = k;
                    lr_rdata = rsp_rdata; lr_err = rsp_err; lr_to = rsp_timeout;
                end
                prev_rv = rsp_valid;
            end
        end
    end

    int b_psel, b_pen, b_rv;

    // Issue one command and wait (bounded) for the model to return to IDLE.
    task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                          input int nwait, input logic [31:0] rdata, input logic slverr,
                          input int rd, input logic hold_valid);
        int i;
        b_psel = cnt_psel; b_pen = cnt_pen; b_rv = cnt_rv;
        t_write = wr; t_nwait = nwait; t_rdata = rdata; t_slverr = slverr; t_rd = rd;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = hold_valid; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_write = ~wr;
        for (i = 0; i < 200 && active; i++) begin
            @(posedge pclk); #1;
        end
        cmd_valid = 1'b0;
        if (active) begin
            errors++;
            $display("FAIL txn_bound: transfer still active after %0d cycles", i);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = '1; cmd_wdata = '1;
        t_write = 0; t_nwait = 0; t_rdata = 0; t_slverr = 0; t_rd = 0;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b0; cmd_valid = 1'b0;
        @(negedge pclk);
        chk("cmd_ready_after_reset", cmd_ready, 1);
        @(posedge pclk); #1;

        // Zero-wait write: SETUP cycle 1, ACCESS cycle 2, response cycle 3.
        do_txn(1'b1, 4'h4, 32'h0000_0001, 0, 32'h0, 1'b0, 0, 1'b0);
        chk("zw_psel_cycles", cnt_psel - b_psel, 2);
        chk("zw_penable_cycles", cnt_pen - b_pen, 1);
        chk("zw_rsp_cycle", rv_k, 3);
        chk("zw_rsp_err", lr_err, 0);
        chk("zw_rsp_rdata", lr_rdata, 0);

        // Wait-state read: 3 low-pready cycles then data.
        do_txn(1'b0, 4'h0, 32'h0, 3, 32'h0000_00A5, 1'b0, 0, 1'b0);
        chk("ws_psel_cycles", cnt_psel - b_psel, 5);
        chk("ws_access_cycles", cnt_pen - b_pen, 4);
        chk("ws_rsp_rdata", lr_rdata, 32'hA5);

        // Slave error on completion.
        do_txn(1'b0, 4'h8, 32'h0, 1, 32'h1234_5678, 1'b1, 0, 1'b0);
        chk("se_rsp_err", lr_err, 1);
        chk("se_rsp_timeout", lr_to, 0);

        // Timeout with pready stuck low, then a normal transfer.
        do_txn(1'b0, 4'hC, 32'h0, 40, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        chk("to_access_cycles", cnt_pen - b_pen, 16);
        chk("to_rsp_err", lr_err, 1);
        chk("to_rsp_timeout", lr_to, 1);
        chk("to_rsp_rdata", lr_rdata, 0);
        do_txn(1'b0, 4'h3, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        chk("after_to_rdata", lr_rdata, 32'hDEAD_BEEF);
        chk("after_to_err", lr_err, 0);

        // pready arrives in the last permitted ACCESS cycle: completion wins.
        do_txn(1'b0, 4'h6, 32'h0, 15, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
        chk("edge_access_cycles", cnt_pen - b_pen, 16);
        chk("edge_rsp_timeout", lr_to, 0);
        chk("edge_rsp_rdata", lr_rdata, 32'h0BAD_F00D);

        // Backpressure: rsp_ready low 5 cycles, competing command held valid.
        do_txn(1'b1, 4'hA, 32'hCAFE_0001, 2, 32'h0, 1'b0, 5, 1'b1);
        chk("bp_rsp_valid_cycles", cnt_rv - b_rv, 6);
        chk("bp_pwdata_last", pwdata, 32'hCAFE_0001);

        // Back-to-back zero-wait transfers.
        do_txn(1'b1, 4'h1, 32'h1111_1111, 0, 32'h0, 1'b0, 0, 1'b0);
        do_txn(1'b0, 4'h2, 32'h0, 0, 32'h2222_2222, 1'b0, 0, 1'b0);
        chk("b2b_rdata", lr_rdata, 32'h2222_2222);

        // Reset asserted during ACCESS: bus idles, no response ever appears.
        b_rv = cnt_rv;
        t_write = 1'b0; t_nwait = 10; t_rdata = 32'h5555_5555; t_slverr = 1'b0; t_rd = 0;
        cmd_write = 1'b0; cmd_addr = 4'h9; cmd_wdata = '0; cmd_valid = 1'b1;
        @(posedge pclk); #1 cmd_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b1;
        @(negedge pclk);
        chk("mr_penable_before_edge", penable, 1);
        @(negedge pclk);
        chk("mr_psel_after_edge", psel, 0);
        chk("mr_penable_after_edge", penable, 0);
        @(posedge pclk); #1 reset = 1'b0;
        repeat (20) @(posedge pclk);
        #1;
        chk("mr_no_response", cnt_rv - b_rv, 0);

        do_txn(1'b0, 4'h5, 32'h0, 0, 32'h7777_0000, 1'b0, 0, 1'b0);
        chk("mr_recover_rdata", lr_rdata, 32'h7777_0000);

        repeat (2) @(posedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
